// File: rtl/thiele_sched_pkg.sv
// Shared definitions for the solver job scheduler: FSM encoding, payload widths,
// colour codes and the response payload struct.
package thiele_sched_pkg;

   localparam int unsigned COLOUR_W = 18;
   localparam int unsigned MU_W     = 8;
   localparam int unsigned ST_W     = 3;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;

   typedef enum logic [1:0] {
      RED   = 2'd0,
      GREEN = 2'd1,
      BLUE  = 2'd2
   } colour_e;

   typedef struct packed {
      logic                success;
      logic                timeout;
      logic [COLOUR_W-1:0] colouring;
      logic [MU_W-1:0]     mu;
   } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   localparam int unsigned IW = $clog2(N);

   always_comb begin
      logic [IW-1:0] cand;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IW'((32'(ptr_i) + i) % N);
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
      if (any_o) begin
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/solver_job_arbiter.sv
// Shares one graph solver among NUM_REQ requesters: round-robin accept, start/done
// sequencing with a watchdog, response return and a saturating mu ledger.
// Optional per-requester mu budget enabled by defining SOLVER_MU_BUDGET_EN.
module solver_job_arbiter
   import thiele_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned LEDGER_W = 16
`ifdef SOLVER_MU_BUDGET_EN
   ,
   parameter int unsigned MU_BUDGET = 32
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic                       rsp_success,
   output logic                       rsp_timeout,
   output logic [17:0]                rsp_colouring,
   output logic [7:0]                 rsp_mu,
   output logic                       slv_start,
   output logic                       slv_reset,
   input  logic                       slv_done,
   input  logic                       slv_success,
   input  logic [17:0]                slv_colouring,
   input  logic [7:0]                 slv_mu_cost,
   output logic [LEDGER_W-1:0]        mu_total,
   output logic                       busy
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned WD_W  = $clog2(TIMEOUT);
   localparam int unsigned SUM_W = LEDGER_W + 1;

   logic [ST_W-1:0]     state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;
   rsp_t                rsp_q, rsp_d;
   logic [LEDGER_W-1:0] mu_total_q, mu_total_d;
   logic                slv_start_q, slv_start_d;
   logic                slv_reset_q, slv_reset_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                busy_q, busy_d;

   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic                any_grant;
   logic [SUM_W-1:0]    ledger_sum;

`ifdef SOLVER_MU_BUDGET_EN
   logic [LEDGER_W-1:0] spent_q [NUM_REQ];
   logic [LEDGER_W-1:0] spent_d [NUM_REQ];
   logic [SUM_W-1:0]    spent_sum;
`endif

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (any_grant)
   );

   // Acceptance is only offered in IDLE, and never while reset is asserted.
   assign req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;

   assign ledger_sum = {1'b0, mu_total_q} + SUM_W'(slv_mu_cost);
`ifdef SOLVER_MU_BUDGET_EN
   assign spent_sum  = {1'b0, spent_q[id_q]} + SUM_W'(slv_mu_cost);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         wdog_q      <= '0;
         rsp_q       <= '0;
         mu_total_q  <= '0;
         slv_start_q <= 1'b0;
         slv_reset_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SOLVER_MU_BUDGET_EN
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            spent_q[i] <= '0;
         end
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         wdog_q      <= wdog_d;
         rsp_q       <= rsp_d;
         mu_total_q  <= mu_total_d;
         slv_start_q <= slv_start_d;
         slv_reset_q <= slv_reset_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
`ifdef SOLVER_MU_BUDGET_EN
         spent_q     <= spent_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      wdog_d      = wdog_q;
      rsp_d       = rsp_q;
      mu_total_d  = mu_total_q;
      slv_reset_d = 1'b0;
`ifdef SOLVER_MU_BUDGET_EN
      spent_d     = spent_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (any_grant) begin
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
               state_d  = ST_ISSUE;
`ifdef SOLVER_MU_BUDGET_EN
               // Over-budget requesters get an immediate empty response.
               if (spent_q[grant_idx] >= LEDGER_W'(MU_BUDGET)) begin
                  rsp_d   = '0;
                  state_d = ST_RESP;
               end
`endif
            end
         end
         ST_ISSUE: begin
            wdog_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wdog_d = wdog_q + WD_W'(1);
            if (slv_done) begin
               rsp_d.success   = slv_success;
               rsp_d.timeout   = 1'b0;
               rsp_d.colouring = slv_colouring;
               rsp_d.mu        = slv_mu_cost;
               mu_total_d      = ledger_sum[LEDGER_W] ? '1 : ledger_sum[LEDGER_W-1:0];
`ifdef SOLVER_MU_BUDGET_EN
               spent_d[id_q]   = spent_sum[LEDGER_W] ? '1 : spent_sum[LEDGER_W-1:0];
`endif
               state_d         = ST_RELEASE;
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               slv_reset_d     = 1'b1;
               rsp_d           = '0;
               rsp_d.timeout   = 1'b1;
               state_d         = ST_RESP;
            end
         end
         ST_RELEASE: begin
            if (!slv_done) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      slv_start_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      rsp_valid_d = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = id_q;
   assign rsp_success   = rsp_q.success;
   assign rsp_timeout   = rsp_q.timeout;
   assign rsp_colouring = rsp_q.colouring;
   assign rsp_mu        = rsp_q.mu;
   assign slv_start     = slv_start_q;
   assign slv_reset     = slv_reset_q;
   assign mu_total      = mu_total_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_solver_job_arbiter.sv
// Self-checking bench for solver_job_arbiter: directed and randomized jobs against
// a behavioural model of arbitration order, response contents and the mu ledger.
module tb_solver_job_arbiter;
   import thiele_sched_pkg::*;

   localparam int TIMEOUT_TB = 64;
   localparam int LEDGER_MAX = 65535;
`ifdef SOLVER_MU_BUDGET_EN
   localparam int MU_BUDGET_TB = 32;
`endif

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic        rsp_success;
   logic        rsp_timeout;
   logic [17:0] rsp_colouring;
   logic [7:0]  rsp_mu;
   logic        slv_start;
   logic        slv_reset;
   logic        slv_done;
   logic        slv_success;
   logic [17:0] slv_colouring;
   logic [7:0]  slv_mu_cost;
   logic [15:0] mu_total;
   logic        busy;

   int n_tests;
   int n_fail;
   int m_ptr;
   int m_total;
   int m_spent [4];

   solver_job_arbiter #(.NUM_REQ(4), .TIMEOUT(TIMEOUT_TB), .LEDGER_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_success   (rsp_success),
      .rsp_timeout   (rsp_timeout),
      .rsp_colouring (rsp_colouring),
      .rsp_mu        (rsp_mu),
      .slv_start     (slv_start),
      .slv_reset     (slv_reset),
      .slv_done      (slv_done),
      .slv_success   (slv_success),
      .slv_colouring (slv_colouring),
      .slv_mu_cost   (slv_mu_cost),
      .mu_total      (mu_total),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [17:0] rand_col();
      logic [17:0] c;
      colour_e     e;
      c = '0;
      for (int n = 0; n < 9; n++) begin
         e = colour_e'(2'($urandom_range(0, 2)));
         c[2*n +: 2] = e;
      end
      return c;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_total = 0;
      for (int i = 0; i < 4; i++) m_spent[i] = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_start"},  32'(slv_start), 0);
      chk({tag, "_sreset"}, 32'(slv_reset), 0);
      chk({tag, "_rvalid"}, 32'(rsp_valid), 0);
      chk({tag, "_ledger"}, 32'(mu_total), 0);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_rfields"}, 32'({rsp_id, rsp_success, rsp_timeout, rsp_mu}), 0);
      chk({tag, "_rcol"},   32'(rsp_colouring), 0);
      chk({tag, "_rready"}, 32'(req_ready), 0);
   endtask

   // One complete transaction: starts and ends just after a falling edge, DUT idle.
   task automatic run_job(input logic [3:0] reqs, input int lat, input bit hang,
                          input bit succ, input logic [17:0] col, input logic [7:0] mu,
                          input int bp, output int got_id);
      int          g;
      int          n_start;
      int          n_rst;
      bit          denied;
      bit          e_succ;
      bit          e_to;
      logic [17:0] e_col;
      logic [7:0]  e_mu;

      g = model_grant(reqs, m_ptr);
      req_valid = reqs;
      #1;
      chk("req_ready", 32'(req_ready), 32'(1) << g);
      chk("busy_idle", 32'(busy), 0);
      @(negedge clk);
      req_valid = '0;
      m_ptr = (g + 1) % 4;
      denied = 1'b0;
`ifdef SOLVER_MU_BUDGET_EN
      denied = (m_spent[g] >= MU_BUDGET_TB);
`endif
      n_rst = 0;
      e_succ = 1'b0; e_to = 1'b0; e_col = '0; e_mu = '0;
      if (denied) begin
         chk("deny_no_start", 32'(slv_start), 0);
      end else begin
         chk("start_latency", 32'(slv_start), 1);
         if (hang) begin
            n_start = 0;
            for (int k = 0; k < 200; k++) begin
               @(negedge clk);
               if (rsp_valid) break;
               if (slv_start) n_start++;
               if (slv_reset) n_rst++;
            end
            if (slv_reset) n_rst++;
            chk("wdog_wait_cycles", 32'(n_start), TIMEOUT_TB);
            e_to = 1'b1;
         end else begin
            repeat (lat) @(negedge clk);
            chk("start_held", 32'(slv_start), 1);
            slv_done = 1'b1; slv_success = succ; slv_colouring = col; slv_mu_cost = mu;
            @(negedge clk);
            m_total = (m_total + int'(mu) > LEDGER_MAX) ? LEDGER_MAX : m_total + int'(mu);
            m_spent[g] = (m_spent[g] + int'(mu) > LEDGER_MAX) ? LEDGER_MAX : m_spent[g] + int'(mu);
            chk("release_start", 32'(slv_start), 0);
            chk("ledger_capture", 32'(mu_total), m_total);
            chk("release_hold0", 32'(rsp_valid), 0);
            @(negedge clk);
            chk("release_hold1", 32'(rsp_valid), 0);
            slv_done = 1'b0; slv_success = 1'b0; slv_colouring = '0; slv_mu_cost = '0;
            @(negedge clk);
            e_succ = succ; e_col = col; e_mu = mu;
         end
      end
      got_id = int'(rsp_id);
      req_valid = 4'($urandom_range(1, 15));
      for (int k = 0; k <= bp; k++) begin
         #1;
         chk("resp_req_ready", 32'(req_ready), 0);
         chk("rsp_valid", 32'(rsp_valid), 1);
         chk("rsp_id", 32'(rsp_id), g);
         chk("rsp_success", 32'(rsp_success), 32'(e_succ));
         chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
         chk("rsp_colouring", 32'(rsp_colouring), 32'(e_col));
         chk("rsp_mu", 32'(rsp_mu), 32'(e_mu));
         chk("mu_total", 32'(mu_total), m_total);
         chk("busy_resp", 32'(busy), 1);
         if (k < bp) begin
            @(negedge clk);
            if (slv_reset) n_rst++;
         end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 0);
      chk("busy_back_idle", 32'(busy), 0);
      chk("sreset_low", 32'(slv_reset), 0);
      chk("sreset_pulses", 32'(n_rst), 32'(hang && !denied));
   endtask

   initial begin
      int          got;
      logic [3:0]  r;
      int          sat_extra;

      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      slv_done = 1'b0;
      slv_success = 1'b0;
      slv_colouring = '0;
      slv_mu_cost = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("por");
      reset = 1'b0;

      // Single job from requester 1, then pointer lands on 2.
      run_job(4'b0010, 3, 1'b0, 1'b1, rand_col(), 8'd14, 0, got);
      chk("single_id", 32'(got), 1);
      run_job(4'b0011, 2, 1'b0, 1'b1, rand_col(), 8'd5, 1, got);
      chk("ptr_wrap_id", 32'(got), 0);

      // Watchdog abort, then done on the very last watchdog cycle.
      run_job(4'b0100, 0, 1'b1, 1'b0, '0, 8'd0, 2, got);
      run_job(4'b1000, TIMEOUT_TB, 1'b0, 1'b1, rand_col(), 8'd9, 0, got);

      // Long response backpressure.
      run_job(4'b0110, 5, 1'b0, 1'b0, rand_col(), 8'd33, 10, got);

      // Randomized jobs.
      for (int i = 0; i < 40; i++) begin
         r = 4'($urandom_range(1, 15));
         run_job(r, $urandom_range(1, 12), ($urandom_range(0, 9) == 0), 1'($urandom),
                 rand_col(), 8'($urandom), $urandom_range(0, 3), got);
      end

      // Ledger saturation.
      sat_extra = 0;
      for (int i = 0; i < 300 && sat_extra < 2; i++) begin
         run_job(4'b1111, 1, 1'b0, 1'b1, rand_col(), 8'd255, 0, got);
         if (m_total == LEDGER_MAX) sat_extra++;
      end
      chk("ledger_clamp", 32'(mu_total), m_total);

      // Synchronous reset in the middle of a WAIT.
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);
      chk("pre_reset_wait", 32'(slv_start), 1);
      reset = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("reset_rready", 32'(req_ready), 0);
      @(negedge clk);
      check_all_zero("midrun_reset");
      reset = 1'b0;
      req_valid = '0;
      model_reset();

      // Fairness with every requester asserting.
      for (int i = 0; i < 8; i++) begin
         run_job(4'b1111, $urandom_range(1, 4), 1'b0, 1'b1, rand_col(), 8'd1, 0, got);
         chk("fair_order", 32'(got), 32'(i % 4));
      end

      // Requester 0 spends past the budget, then asks again.
      run_job(4'b0001, 2, 1'b0, 1'b1, rand_col(), 8'd20, 0, got);
      run_job(4'b0001, 2, 1'b0, 1'b1, rand_col(), 8'd13, 0, got);
      run_job(4'b0001, 2, 1'b0, 1'b1, rand_col(), 8'd7, 0, got);
      chk("budget_id", 32'(got), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
